// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-client round-robin arbiter/sequencer for a 16x8 dual-port memory
module mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                grant;
    logic                grant_b;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                lat_we;
    logic                lat_client;
    logic                last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // last_grant=1 means B was served last, so A wins the next tie.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_b   = 1'b0;
        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    grant     = 1'b1;
                    grant_b   = b_req && (!a_req || !last_grant);
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        sel_we    = grant_b ? b_we    : a_we;
        sel_addr  = grant_b ? b_addr  : a_addr;
        sel_wdata = grant_b ? b_wdata : a_wdata;
    end

    // The mem_* registers are loaded at the grant edge and so double as the latched command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we     <= 1'b0;
            lat_client <= 1'b0;
            last_grant <= 1'b1;
            mem_w_en   <= 1'b0;
            mem_w_addr <= '0;
            mem_w_data <= '0;
            mem_r_en   <= 1'b0;
            mem_r_addr <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            busy       <= 1'b0;
        end else begin
            mem_w_en   <= grant && sel_we;
            mem_w_addr <= (grant && sel_we) ? sel_addr : '0;
            mem_w_data <= (grant && sel_we) ? sel_wdata : '0;
            mem_r_en   <= grant && !sel_we;
            mem_r_addr <= (grant && !sel_we) ? sel_addr : '0;
            if (grant) begin
                lat_we     <= sel_we;
                lat_client <= grant_b;
                last_grant <= grant_b;
            end
            if (state == WAIT && !lat_we) begin
                if (lat_client) begin
                    b_rdata <= mem_r_data;
                end else begin
                    a_rdata <= mem_r_data;
                end
            end
            a_ack <= (state == DONE) && !lat_client;
            b_ack <= (state == DONE) && lat_client;
            busy  <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a 16x8 memory model
module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    logic       a_req, a_we, b_req, b_we;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_ack, b_ack;
    logic [7:0] a_rdata, b_rdata;
    logic       mem_w_en, mem_r_en;
    logic [3:0] mem_w_addr, mem_r_addr;
    logic [7:0] mem_w_data, mem_r_data;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int w_cnt = 0, r_cnt = 0, dual_en = 0, a_ack_cnt = 0, b_ack_cnt = 0;
    logic [3:0] last_w_addr;
    logic [7:0] last_w_data;
    logic [7:0] mem [16];

    mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
        .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
        if (mem_r_en) mem_r_data <= mem[mem_r_addr];
    end

    always @(posedge clk) begin
        if (mem_w_en) begin
            w_cnt++;
            last_w_addr = mem_w_addr;
            last_w_data = mem_w_data;
        end
        if (mem_r_en) r_cnt++;
        if (mem_w_en && mem_r_en) dual_en++;
        if (a_ack) a_ack_cnt++;
        if (b_ack) b_ack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request, wait (bounded) for its ack, check latency and read data.
    task automatic run_txn(input string tag, input logic cl, input logic we,
                           input logic [3:0] addr, input logic [7:0] wd, input logic [7:0] exp_rd);
        int  n;
        logic got;
        if (cl) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            got = cl ? b_ack : a_ack;
        end
        check({tag, "_latency"}, n, 4);
        if (!we) check({tag, "_rdata"}, cl ? b_rdata : a_rdata, exp_rd);
        if (cl) b_req = 1'b0; else a_req = 1'b0;
        tick();
        check({tag, "_ack_one_cycle"}, cl ? b_ack : a_ack, 0);
    endtask

    initial begin
        int a0, b0, r0;
        rst = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;

        // Test 1: async reset before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_mem_en", {mem_w_en, mem_r_en}, 0);
        check("rst_mem_bus", {mem_w_addr, mem_w_data, mem_r_addr}, 0);
        check("rst_ack", {a_ack, b_ack}, 0);
        check("rst_rdata", {a_rdata, b_rdata}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Test 2: A writes A5 to F, then reads it back
        run_txn("t2_wr", 1'b0, 1'b1, 4'hF, 8'hA5, 8'h00);
        check("t2_w_cnt", w_cnt, 1);
        check("t2_w_addr", last_w_addr, 4'hF);
        check("t2_w_data", last_w_data, 8'hA5);
        check("t2_r_cnt0", r_cnt, 0);
        run_txn("t2_rd", 1'b0, 1'b0, 4'hF, 8'h00, 8'hA5);
        check("t2_r_cnt1", r_cnt, 1);
        check("t2_w_cnt_after", w_cnt, 1);
        check("t2_b_ack_quiet", b_ack_cnt, 0);

        // Test 3: simultaneous requests after a fresh reset; A wins the first tie
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_req = 1; a_we = 1; a_addr = 4'h2; a_wdata = 8'h3C;
        b_req = 1; b_we = 0; b_addr = 4'h2;
        tick();
        check("t3_a_first_wen", mem_w_en, 1);
        check("t3_a_first_ren", mem_r_en, 0);
        check("t3_a_waddr", mem_w_addr, 4'h2);
        check("t3_a_wdata", mem_w_data, 8'h3C);
        tick(); tick(); tick();
        check("t3_a_ack", {a_ack, b_ack}, 2'b10);
        a_req = 0;
        tick();
        check("t3_b_ren", mem_r_en, 1);
        check("t3_b_raddr", mem_r_addr, 4'h2);
        check("t3_b_wen", mem_w_en, 0);
        tick(); tick(); tick();
        check("t3_b_ack", {a_ack, b_ack}, 2'b01);
        check("t3_b_rdata", b_rdata, 8'h3C);
        b_req = 0;
        tick();

        // Test 4: both hold requests for six transactions
        r0 = r_cnt;
        a_req = 1; a_we = 0; a_addr = 4'h2;
        b_req = 1; b_we = 0; b_addr = 4'hF;
        for (int i = 1; i <= 24; i++) begin
            tick();
            check($sformatf("t4_busy_%0d", i), busy, (i % 4) != 0);
            if ((i % 4) == 0) begin
                check($sformatf("t4_acks_%0d", i), {a_ack, b_ack},
                      (((i / 4) % 2) == 1) ? 2'b10 : 2'b01);
            end
        end
        a_req = 0; b_req = 0;
        tick();
        check("t4_enables", r_cnt - r0, 6);
        check("t4_dual_en", dual_en, 0);
        check("t4_a_rdata", a_rdata, 8'h3C);
        check("t4_b_rdata", b_rdata, 8'hA5);
        check("t4_idle", busy, 0);

        // Test 5: B changes its address after the grant
        b_req = 1; b_we = 0; b_addr = 4'h2;
        tick();
        b_addr = 4'h0;
        check("t5_ren", mem_r_en, 1);
        check("t5_raddr", mem_r_addr, 4'h2);
        tick(); tick(); tick();
        check("t5_b_ack", b_ack, 1);
        check("t5_b_rdata", b_rdata, 8'h3C);
        b_req = 0;
        tick();

        // Test 6: reset during WAIT of an A read
        a0 = a_ack_cnt;
        b0 = b_ack_cnt;
        a_req = 1; a_we = 0; a_addr = 4'hF;
        tick();
        check("t6_issue_ren", mem_r_en, 1);
        tick();
        #3 rst = 1'b1;
        a_req = 0;
        #1;
        check("t6_rst_rdata", a_rdata, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ren", mem_r_en, 0);
        check("t6_rst_ack", a_ack, 0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick(); tick();
        check("t6_no_a_ack", a_ack_cnt - a0, 0);
        check("t6_no_b_ack", b_ack_cnt - b0, 0);
        check("t6_idle", busy, 0);
        run_txn("t6_rereq", 1'b0, 1'b0, 4'hF, 8'h00, 8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
